// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: controller state
// encodings, geometry helpers and the tree-PLRU update/victim functions.
package icache_pkg;

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_MISS  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int LINE_W = 128;

  function automatic int tag_width(input int addr_w, input int set_w);
    return addr_w - 2 - set_w;
  endfunction

  function automatic int way_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Each bit points away from the most recent access; b0 picks the pair.
  function automatic logic [2:0] plru_update(input logic [2:0] st, input logic [1:0] way,
                                              input int ways);
    logic [2:0] nx;
    nx = st;
    if (ways == 2) begin
      nx[0] = ~way[0];
    end else if (ways == 4) begin
      nx[0] = ~way[1];
      if (way[1]) nx[2] = ~way[0];
      else        nx[1] = ~way[0];
    end else begin
      nx = 3'b000;
    end
    return nx;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] st, input int ways);
    logic [1:0] v;
    if (ways == 2)      v = {1'b0, st[0]};
    else if (ways == 4) v = st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
    else                v = 2'b00;
    return v;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree-PLRU replacement state with update, victim lookup and clear ports.
module icache_plru
  import icache_pkg::*;
#(
  parameter int SET_W = 2,
  parameter int WAYS  = 2,
  parameter int WAY_W = way_width(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_upd_en,
  input  logic [SET_W-1:0] i_upd_set,
  input  logic [WAY_W-1:0] i_upd_way,
  input  logic [SET_W-1:0] i_vic_set,
  output logic [WAY_W-1:0] o_vic_way,
  input  logic             i_clr_en,
  input  logic [SET_W-1:0] i_clr_set
);

  localparam int SETS = 1 << SET_W;

  logic [2:0] r_plru [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= 3'b000;
    end else if (i_clr_en) begin
      r_plru[i_clr_set] <= 3'b000;
    end else if (i_upd_en) begin
      r_plru[i_upd_set] <= plru_update(r_plru[i_upd_set], 2'(i_upd_way), WAYS);
    end
  end

  assign o_vic_way = WAY_W'(plru_victim(r_plru[i_vic_set], WAYS));

endmodule

// File: rtl/cache_i_assoc.sv
// Read-only N-way set-associative instruction cache: 4-word line refill per miss,
// PLRU replacement, fence.i flush sweep and saturating hit/miss counters.
module cache_i_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int SET_W  = 2,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  input  logic              proc_flush,
  input  logic              cnt_clr,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W = tag_width(ADDR_W, SET_W);
  localparam int SETS  = 1 << SET_W;
  localparam int WAY_W = way_width(WAYS);

  if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
    $error("cache_i_assoc: WAYS must be 1, 2 or 4");
  end

  logic [LINE_W-1:0] r_data  [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [WAYS-1:0]   r_valid [SETS];
  logic [1:0]        r_state;
  logic              r_pend;
  logic [SET_W-1:0]  r_flush_set;
  logic              r_mem_read;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [SET_W-1:0]  w_set, w_rf_set;
  logic [TAG_W-1:0]  w_tag, w_rf_tag;
  logic [WAYS-1:0]   w_match;
  logic              w_hit, w_hit_upd, w_miss_start, w_refill;
  logic [WAY_W-1:0]  w_hit_way, w_vic, w_plru_vic;
  logic [LINE_W-1:0] w_line;
  logic              w_unused;

  assign w_set    = proc_addr[SET_W+1:2];
  assign w_tag    = proc_addr[ADDR_W-1:SET_W+2];
  assign w_rf_set = r_mem_addr[SET_W-1:0];
  assign w_rf_tag = r_mem_addr[ADDR_W-3:SET_W];
  assign w_unused = ^{proc_write, proc_wdata};

  // Tag lookup in the indexed set; tags are unique so at most one way matches.
  always_comb begin
    w_hit_way = {WAY_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      w_match[w] = r_valid[w_set][w] && (r_tag[w_set][w] == w_tag);
      w_hit_way  = w_match[w] ? WAY_W'(w) : w_hit_way;
    end
    w_hit = proc_read && (|w_match);
  end

  assign w_line     = r_data[w_set][w_hit_way];
  assign proc_rdata = w_hit ? w_line[{proc_addr[1:0], 5'b00000} +: 32] : 32'h0;

  // Refill victim: lowest-index invalid way, otherwise the PLRU choice.
  always_comb begin
    w_vic = w_plru_vic;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_vic = !r_valid[w_rf_set][w] ? WAY_W'(w) : w_vic;
    end
  end

  assign w_hit_upd    = (r_state == ST_READY) && w_hit;
  assign w_miss_start = (r_state == ST_READY) && proc_read && !w_hit && !r_pend && !proc_flush;
  assign w_refill     = (r_state == ST_MISS) && mem_ready;
  assign proc_stall   = (r_state == ST_READY) ? ((proc_read && !w_hit) || r_pend) : 1'b1;

  icache_plru #(.SET_W(SET_W), .WAYS(WAYS), .WAY_W(WAY_W)) u_plru (
    .clk       (clk),
    .rst_n     (proc_reset_n),
    .i_upd_en  (w_hit_upd || w_refill),
    .i_upd_set (w_refill ? w_rf_set : w_set),
    .i_upd_way (w_refill ? w_vic : w_hit_way),
    .i_vic_set (w_rf_set),
    .o_vic_way (w_plru_vic),
    .i_clr_en  (r_state == ST_FLUSH),
    .i_clr_set (r_flush_set)
  );

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state     <= ST_READY;
      r_pend      <= 1'b0;
      r_flush_set <= {SET_W{1'b0}};
      r_mem_read  <= 1'b0;
      r_mem_addr  <= {(ADDR_W-2){1'b0}};
      for (int s = 0; s < SETS; s++) r_valid[s] <= {WAYS{1'b0}};
    end else begin
      case (r_state)
        ST_READY: begin
          if (proc_flush || r_pend) begin
            r_state     <= ST_FLUSH;
            r_flush_set <= {SET_W{1'b0}};
            r_pend      <= 1'b0;
          end else if (w_miss_start) begin
            r_state    <= ST_MISS;
            r_mem_read <= 1'b1;
            r_mem_addr <= proc_addr[ADDR_W-1:2];
          end
        end
        ST_MISS: begin
          // A flush seen during the refill waits until the line is installed.
          if (mem_ready) begin
            r_mem_read                <= 1'b0;
            r_valid[w_rf_set][w_vic]  <= 1'b1;
            r_state                   <= (r_pend || proc_flush) ? ST_FLUSH : ST_READY;
            r_flush_set               <= {SET_W{1'b0}};
            r_pend                    <= 1'b0;
          end else if (proc_flush) begin
            r_pend <= 1'b1;
          end
        end
        ST_FLUSH: begin
          r_valid[r_flush_set] <= {WAYS{1'b0}};
          r_flush_set          <= r_flush_set + 1'b1;
          if (r_flush_set == SET_W'(SETS - 1)) r_state <= ST_READY;
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  // Line payload and tag storage carry no reset; validity gates their use.
  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_data[w_rf_set][w_vic] <= mem_rdata;
      r_tag[w_rf_set][w_vic]  <= w_rf_tag;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_hit_cnt  <= {CNT_W{1'b0}};
      r_miss_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      r_hit_cnt  <= {CNT_W{1'b0}};
      r_miss_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_hit_upd && (r_hit_cnt != {CNT_W{1'b1}}))     r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (w_miss_start && (r_miss_cnt != {CNT_W{1'b1}})) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_addr  = r_mem_addr;
  assign mem_write = 1'b0;
  assign mem_wdata = 128'h0;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_cache_i_assoc.sv
// Directed self-checking bench for cache_i_assoc (2-way, 4 sets, 4-bit counters).
module tb_cache_i_assoc;

  localparam int ADDR_W = 30;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n, rd, wr, flush, clr, mready;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata, rdata;
  logic              stall, mread, mwrite;
  logic [ADDR_W-3:0] maddr;
  logic [127:0]      mwdata, mrdata;
  logic [CNT_W-1:0]  hcnt, mcnt;
  int                n_tests = 0;
  int                n_fail  = 0;
  logic [127:0]      l1, l2, l3, l4, l5, l6, l7;

  always #5 clk = ~clk;

  cache_i_assoc #(.ADDR_W(ADDR_W), .SET_W(2), .WAYS(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .proc_reset_n(rst_n), .proc_read(rd), .proc_write(wr), .proc_addr(addr),
    .proc_wdata(wdata), .proc_flush(flush), .cnt_clr(clr), .proc_rdata(rdata),
    .proc_stall(stall), .mem_read(mread), .mem_write(mwrite), .mem_addr(maddr),
    .mem_wdata(mwdata), .mem_rdata(mrdata), .mem_ready(mready), .hit_cnt(hcnt),
    .miss_cnt(mcnt)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Full miss: request, one cycle of mem_read, refill; returns at the cycle after mem_ready.
  task automatic fill(input logic [ADDR_W-1:0] a, input logic [127:0] line, input string tag);
    logic [ADDR_W-3:0] exp_line;
    exp_line = a[ADDR_W-1:2];
    @(negedge clk); rd = 1'b1; addr = a; #1;
    check({tag, "_stall"}, stall, 1'b1);
    @(negedge clk);
    check({tag, "_mread"}, mread, 1'b1);
    check({tag, "_maddr"}, maddr, exp_line);
    mready = 1'b1; mrdata = line;
    @(negedge clk); mready = 1'b0; #1;
    check({tag, "_done"}, stall, 1'b0);
  endtask

  task automatic hit(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk); rd = 1'b1; addr = a; #1;
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_rdata"}, rdata, exp);
  endtask

  // Presents a read, expects a miss, then withdraws it so no refill is launched.
  task automatic probe_miss(input logic [ADDR_W-1:0] a, input string tag);
    @(negedge clk); rd = 1'b1; addr = a; #1;
    check({tag, "_stall"}, stall, 1'b1);
    check({tag, "_rdata"}, rdata, 32'h0);
    rd = 1'b0;
  endtask

  task automatic count_stall(input int n, input int exp, input string tag);
    int c;
    c = 0;
    repeat (n) begin
      #1; c += int'(stall);
      @(negedge clk);
    end
    check(tag, c, exp);
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = 32'hDEAD_BEEF;
    flush = 1'b0; clr = 1'b0; mready = 1'b0; mrdata = '0;
    l1 = mk_line(32'hA000_0000); l2 = mk_line(32'hB000_0000); l3 = mk_line(32'hC000_0000);
    l4 = mk_line(32'hD000_0000); l5 = mk_line(32'hE000_0000); l6 = mk_line(32'hF000_0000);
    l7 = mk_line(32'h1234_0000);
    repeat (2) @(negedge clk);
    #1;
    check("rst_mread", mread, 1'b0);
    check("rst_maddr", maddr, 28'h0);
    check("rst_hcnt", hcnt, 4'd0);
    check("rst_mcnt", mcnt, 4'd0);
    check("rst_stall", stall, 1'b0);
    check("rst_mwrite", mwrite, 1'b0);
    check("rst_mwdata", mwdata, 128'h0);
    rst_n = 1'b1;

    // Cold miss and word select
    fill(30'h10, l1, "t1");
    check("t1_rdata", rdata, 32'hA000_0000);
    check("t1_mread_low", mread, 1'b0);
    check("t1_mcnt", mcnt, 4'd1);
    wr = 1'b1;
    hit(30'h11, 32'hA000_0001, "t2_w1");
    hit(30'h12, 32'hA000_0002, "t2_w2");
    hit(30'h13, 32'hA000_0003, "t2_w3");
    @(negedge clk); rd = 1'b0; wr = 1'b0; #1;
    check("t2_hcnt", hcnt, 4'd4);

    // Replacement: 0x40 becomes LRU after 0x00 is touched, so 0x80 evicts it
    fill(30'h00, l2, "t3a");
    fill(30'h40, l3, "t3b");
    hit(30'h00, 32'hB000_0000, "t3_touch");
    fill(30'h80, l4, "t3c");
    hit(30'h81, 32'hD000_0001, "t3_new");
    hit(30'h02, 32'hB000_0002, "t3_keep");
    probe_miss(30'h40, "t3_evict");
    probe_miss(30'h10, "t3_evict_old");
    #1; check("t3_mcnt", mcnt, 4'd4);

    // Flush from READY
    @(negedge clk); rd = 1'b0; flush = 1'b1; #1;
    check("t4_pulse_stall", stall, 1'b0);
    @(negedge clk); flush = 1'b0;
    count_stall(6, 4, "t4_flush_cycles");
    probe_miss(30'h00, "t4_inv0");
    probe_miss(30'h80, "t4_inv1");

    // Flush pulsed while the refill is outstanding
    @(negedge clk); rd = 1'b1; addr = 30'h10;
    @(negedge clk); #1;
    check("t4m_mread", mread, 1'b1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    check("t4m_stall", stall, 1'b1);
    check("t4m_mread_held", mread, 1'b1);
    mready = 1'b1; mrdata = l5;
    @(negedge clk); mready = 1'b0; rd = 1'b0; #1;
    check("t4m_mread_low", mread, 1'b0);
    count_stall(6, 4, "t4m_flush_cycles");
    probe_miss(30'h10, "t4m_inv");
    #1; check("t4m_mcnt", mcnt, 4'd5);

    // Address change during a miss: line lands at 0x20's set/tag
    @(negedge clk); rd = 1'b1; addr = 30'h20;
    @(negedge clk); #1;
    check("t5_maddr", maddr, 28'h8);
    addr = 30'h30; mready = 1'b1; mrdata = l6;
    @(negedge clk); mready = 1'b0; #1;
    check("t5_other_miss", stall, 1'b1);
    rd = 1'b0;
    hit(30'h22, 32'hF000_0002, "t5_hit");
    probe_miss(30'h30, "t5_miss30");

    // Reset during a miss
    @(negedge clk); rd = 1'b1; addr = 30'h10;
    @(negedge clk); #1;
    check("t6_mread", mread, 1'b1);
    rst_n = 1'b0; #1;
    check("t6_rst_mread", mread, 1'b0);
    check("t6_rst_hcnt", hcnt, 4'd0);
    check("t6_rst_mcnt", mcnt, 4'd0);
    @(negedge clk); rst_n = 1'b1; rd = 1'b0; mready = 1'b1; mrdata = l7;
    @(negedge clk); mready = 1'b0; #1;
    check("t6_late_ready", mread, 1'b0);
    probe_miss(30'h10, "t6_inv10");
    probe_miss(30'h22, "t6_inv20");

    // Hit counter saturation and clear
    fill(30'h10, l7, "t6f");
    repeat (20) hit(30'h11, 32'h1234_0001, "t6_sat");
    @(negedge clk); rd = 1'b0; #1;
    check("t6_hcnt_sat", hcnt, 4'd15);
    check("t6_mcnt", mcnt, 4'd1);
    @(negedge clk); rd = 1'b1; addr = 30'h10; clr = 1'b1;
    @(negedge clk); clr = 1'b0; rd = 1'b0; #1;
    check("t6_clr_hcnt", hcnt, 4'd0);
    check("t6_clr_mcnt", mcnt, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
